regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have one parameter: PTR_INIT, default 0, meaning the round-robin pointer value after reset (0 = requester A first, 1 = requester B first).
REQ-002 The block SHALL have the following ports, one per line:
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  asynchronous active-low reset
- valA  input  1  requester A write request valid
- addrA  input  4  requester A destination register
- dataA  input  16  requester A write data
- rdyA  output  1  requester A may hand over this cycle
- valB  input  1  requester B write request valid
- addrB  input  4  requester B destination register
- dataB  input  16  requester B write data
- rdyB  output  1  requester B may hand over this cycle
- write  output  1  regfile write enable (registered)
- wrAddr  output  4  regfile write address (registered)
- wrData  output  16  regfile write data (registered)
- pending  output  16  per-register in-flight write flag (combinational from state)
REQ-003 write, wrAddr and wrData SHALL connect directly to the 16x16 register file write port, which commits on the next rising clk edge.

Function
REQ-004 Each requester SHALL own a 1-entry holding buffer (full flag, 4-bit address, 16-bit data).
REQ-005 The handshake SHALL complete at a rising edge where valX=1 and rdyX=1; the buffer then captures addrX/dataX and sets full.
REQ-006 rdyX SHALL be 1 when bufX is empty, or when bufX is granted in the current cycle (drain and refill on the same edge); otherwise 0.
REQ-007 Grant SHALL be computed each cycle from buffer state only, never from valX in the same cycle.
- only bufA full -> grant A
- only bufB full -> grant B
- both full -> grant the requester selected by ptr
- none full -> no grant
REQ-008 After any grant, ptr SHALL point to the non-granted requester; with no grant, ptr SHALL hold.
REQ-009 On the edge ending a granted cycle, the output register SHALL load write=1, wrAddr/wrData from the granted buffer, and that buffer SHALL clear unless refilled per REQ-006.
REQ-010 On an edge with no grant, the output register SHALL load write=0, and wrAddr/wrData SHALL hold their previous values.
REQ-011 Latency SHALL be: handshake at edge E0 -> write=1 during the cycle after E1 if uncontended -> regfile commit at E2.
- Under contention the loser is delayed by exactly 1 cycle per competing grant.
- Neither requester can be starved for more than 1 grant while its buffer is full.
REQ-012 Throughput SHALL be one regfile write per cycle while any buffer is full.
REQ-013 pending[r] SHALL be 1 iff (bufA full and its address = r) or (bufB full and its address = r) or (write=1 and wrAddr = r).
REQ-014 When both buffers target the same register, both writes SHALL be issued in grant order; the later grant's data is the final regfile value, and pending[r] stays 1 until that last write's output cycle ends.
REQ-015 wrData and wrAddr SHALL pass through bit-exact; the block performs no arithmetic.

Reset
REQ-016 While rst_n=0, asynchronously: bufA/bufB empty, ptr=PTR_INIT, write=0, wrAddr=0, wrData=0, pending=16'h0000, rdyA=rdyB=0.
REQ-017 Reset asserted mid-operation SHALL discard all buffered and in-flight writes without a partial write; rdyA/rdyB SHALL return to 1 in the first cycle after rst_n deasserts.

Verification
REQ-018 Single write: valA=1, addrA=4'h3, dataA=16'hBEEF for one cycle -> write=1, wrAddr=3, wrData=BEEF exactly 2 edges later; pending[3]=1 from E0 until the write cycle ends.
REQ-019 Contention with PTR_INIT=0: both requesters hand over in the same cycle (A: r1=16'h1111, B: r2=16'h2222) -> A written first, B next cycle, rdyB=0 for one cycle.
REQ-020 Round-robin: both requesters held valid continuously for 8 cycles -> writes alternate A,B,A,B with no idle cycle after the pipe fills.
REQ-021 Same address: A writes r5=16'hAAAA and B writes r5=16'h5555 in the same cycle (ptr=B) -> order B then A, final r5=AAAA, pending[5] clears only after the second write.
REQ-022 Reset mid-flight: rst_n pulsed low while both buffers are full and write=1 -> all outputs at reset values immediately, no further write pulses, regfile contents unchanged from that point.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester round-robin write arbiter feeding a 16x16 register file
module regfile_write_arbiter #(
    parameter logic PTR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valA,
    input  logic [3:0]  addrA,
    input  logic [15:0] dataA,
    output logic        rdyA,
    input  logic        valB,
    input  logic [3:0]  addrB,
    input  logic [15:0] dataB,
    output logic        rdyB,
    output logic        write,
    output logic [3:0]  wrAddr,
    output logic [15:0] wrData,
    output logic [15:0] pending
);

    logic        full_a, full_b;
    logic [3:0]  buf_addr_a, buf_addr_b;
    logic [15:0] buf_data_a, buf_data_b;
    logic        ptr;
    logic        grant_a, grant_b;
    logic        take_a, take_b;

    // Grant depends only on buffer state so a new request never bypasses its buffer
    assign grant_a = full_a & (~full_b | ~ptr);
    assign grant_b = full_b & (~full_a | ptr);

    assign rdyA = rst_n & (~full_a | grant_a);
    assign rdyB = rst_n & (~full_b | grant_b);

    assign take_a = valA & rdyA;
    assign take_b = valB & rdyB;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_a     <= 1'b0;
            full_b     <= 1'b0;
            buf_addr_a <= 4'h0;
            buf_addr_b <= 4'h0;
            buf_data_a <= 16'h0000;
            buf_data_b <= 16'h0000;
            ptr        <= PTR_INIT;
            write      <= 1'b0;
            wrAddr     <= 4'h0;
            wrData     <= 16'h0000;
        end else begin
            if (take_a) begin
                full_a     <= 1'b1;
                buf_addr_a <= addrA;
                buf_data_a <= dataA;
            end else if (grant_a) begin
                full_a <= 1'b0;
            end

            if (take_b) begin
                full_b     <= 1'b1;
                buf_addr_b <= addrB;
                buf_data_b <= dataB;
            end else if (grant_b) begin
                full_b <= 1'b0;
            end

            write <= grant_a | grant_b;
            if (grant_a) begin
                wrAddr <= buf_addr_a;
                wrData <= buf_data_a;
                ptr    <= 1'b1;
            end else if (grant_b) begin
                wrAddr <= buf_addr_b;
                wrData <= buf_data_b;
                ptr    <= 1'b0;
            end
        end
    end

    always_comb begin
        pending = 16'h0000;
        if (full_a) pending[buf_addr_a] = 1'b1;
        if (full_b) pending[buf_addr_b] = 1'b1;
        if (write)  pending[wrAddr]     = 1'b1;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        valA, valB;
    logic [3:0]  addrA, addrB;
    logic [15:0] dataA, dataB;
    logic        rdyA, rdyB;
    logic        write;
    logic [3:0]  wrAddr;
    logic [15:0] wrData;
    logic [15:0] pending;

    logic [15:0] rf [16];
    int checks;
    int errors;

    regfile_write_arbiter #(.PTR_INIT(1'b0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valA    (valA),
        .addrA   (addrA),
        .dataA   (dataA),
        .rdyA    (rdyA),
        .valB    (valB),
        .addrB   (addrB),
        .dataB   (dataB),
        .rdyB    (rdyB),
        .write   (write),
        .wrAddr  (wrAddr),
        .wrData  (wrData),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External register file commits the registered write port
    always @(posedge clk) begin
        if (write) rf[wrAddr] <= wrData;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int na, nb;
        logic pa, pb;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
        rst_n = 1'b0;
        valA = 1'b0; addrA = 4'h0; dataA = 16'h0000;
        valB = 1'b0; addrB = 4'h0; dataB = 16'h0000;
        tick();
        tick();
        check("rst_write", write, 1'b0);
        check("rst_wraddr", wrAddr, 4'h0);
        check("rst_wrdata", wrData, 16'h0000);
        check("rst_pending", pending, 16'h0000);
        check("rst_rdya", rdyA, 1'b0);
        check("rst_rdyb", rdyB, 1'b0);
        rst_n = 1'b1;
        #1;
        check("post_rst_rdya", rdyA, 1'b1);
        check("post_rst_rdyb", rdyB, 1'b1);

        // Contention with ptr at A
        valA = 1'b1; addrA = 4'h1; dataA = 16'h1111;
        valB = 1'b1; addrB = 4'h2; dataB = 16'h2222;
        tick();
        valA = 1'b0; valB = 1'b0;
        check("cont_rdya", rdyA, 1'b1);
        check("cont_rdyb_stall", rdyB, 1'b0);
        check("cont_pending", pending, 16'h0006);
        check("cont_nowrite", write, 1'b0);
        tick();
        check("cont_w1", {write, wrAddr, wrData}, {1'b1, 4'h1, 16'h1111});
        check("cont_rdyb_back", rdyB, 1'b1);
        tick();
        check("cont_w2", {write, wrAddr, wrData}, {1'b1, 4'h2, 16'h2222});
        tick();
        check("cont_idle", write, 1'b0);
        check("cont_rf1", rf[1], 16'h1111);
        check("cont_rf2", rf[2], 16'h2222);
        check("cont_pending_clr", pending, 16'h0000);

        // Single write from A
        valA = 1'b1; addrA = 4'h3; dataA = 16'hBEEF;
        tick();
        valA = 1'b0;
        check("single_pend_e0", pending, 16'h0008);
        check("single_nowrite_e0", write, 1'b0);
        tick();
        check("single_w", {write, wrAddr, wrData}, {1'b1, 4'h3, 16'hBEEF});
        check("single_pend_e1", pending, 16'h0008);
        tick();
        check("single_done", write, 1'b0);
        check("single_hold_addr", wrAddr, 4'h3);
        check("single_pend_e2", pending, 16'h0000);
        check("single_rf3", rf[3], 16'hBEEF);

        // Same address, ptr now selects B
        valA = 1'b1; addrA = 4'h5; dataA = 16'hAAAA;
        valB = 1'b1; addrB = 4'h5; dataB = 16'h5555;
        tick();
        valA = 1'b0; valB = 1'b0;
        check("same_rdya_stall", rdyA, 1'b0);
        check("same_pend0", pending, 16'h0020);
        tick();
        check("same_w1", {write, wrAddr, wrData}, {1'b1, 4'h5, 16'h5555});
        check("same_pend1", pending, 16'h0020);
        tick();
        check("same_w2", {write, wrAddr, wrData}, {1'b1, 4'h5, 16'hAAAA});
        check("same_pend2", pending, 16'h0020);
        tick();
        check("same_idle", write, 1'b0);
        check("same_pend3", pending, 16'h0000);
        check("same_rf5", rf[5], 16'hAAAA);

        // Round-robin streaming: ptr is at B, so writes go B0,A0,B1,A1,...
        na = 0; nb = 0;
        valA = 1'b1; addrA = 4'h8; dataA = 16'hA000;
        valB = 1'b1; addrB = 4'h9; dataB = 16'hB000;
        for (int i = 0; i < 8; i++) begin
            pa = rdyA; pb = rdyB;
            tick();
            if (pa) na++;
            if (pb) nb++;
            dataA = 16'hA000 + 16'(na);
            dataB = 16'hB000 + 16'(nb);
            if (i >= 1) begin
                if (((i - 1) % 2) == 0)
                    check($sformatf("rr_w%0d", i - 1), {write, wrAddr, wrData},
                          {1'b1, 4'h9, 16'hB000 + 16'((i - 1) / 2)});
                else
                    check($sformatf("rr_w%0d", i - 1), {write, wrAddr, wrData},
                          {1'b1, 4'h8, 16'hA000 + 16'((i - 1) / 2)});
            end
        end
        valA = 1'b0; valB = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rr_drained", write, 1'b0);
        check("rr_pend_clr", pending, 16'h0000);

        // Reset while both buffers are full and a write is on the port
        valA = 1'b1; addrA = 4'hA; dataA = 16'h1234;
        valB = 1'b1; addrB = 4'hB; dataB = 16'h5678;
        tick();
        tick();
        check("mid_write_live", write, 1'b1);
        check("mid_pend_live", pending, 16'h0C00);
        valA = 1'b0; valB = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_write", write, 1'b0);
        check("mid_rst_wraddr", wrAddr, 4'h0);
        check("mid_rst_wrdata", wrData, 16'h0000);
        check("mid_rst_pending", pending, 16'h0000);
        check("mid_rst_rdy", {rdyA, rdyB}, 2'b00);
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rel_rdy", {rdyA, rdyB}, 2'b11);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mid_nowrite%0d", i), write, 1'b0);
        end
        check("mid_rf10", rf[10], 16'h0000);
        check("mid_rf11", rf[11], 16'h0000);
        check("mid_rf5_kept", rf[5], 16'hAAAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
